// File: rtl/encoder4to2_sampled_if.sv
// Purpose: signal bundle between a glitch-filtered 4-to-2 encoder and its
//          environment. The slave side is the encoder and the master side is
//          whatever drives the select lines and consumes the code.
// Signals:
//   en        enable, active-low (0 = encoder active)
//   y_n[3:0]  select lines, active-low; 4'b1111 = no line active
//   out_ready consumer accepts the code on an edge while out_valid=1
//   a, b      encoded index {a,b}
//   out_valid {a,b,multi} hold a valid code that has not been accepted yet
//   multi     more than one line was low in the encoded pattern
interface encoder4to2_sampled_if;
  logic       en;
  logic [3:0] y_n;
  logic       out_ready;
  logic       a;
  logic       b;
  logic       out_valid;
  logic       multi;

  modport master (
    output en, y_n, out_ready,
    input  a, b, out_valid, multi
  );

  modport slave (
    input  en, y_n, out_ready,
    output a, b, out_valid, multi
  );
endinterface

// File: rtl/encoder4to2_sampled.sv
// Purpose: encodes four active-low select lines back into a 2-bit index.
//          A line pattern must stay unchanged for STABLE_CYCLES samples before
//          it is encoded. Each activation is issued exactly once through a
//          valid/ready handshake, and is re-armed only after all lines are
//          released or the encoder is disabled.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous, active-high reset
//   bus  encoder4to2_sampled_if.slave (en, y_n, out_ready -> a, b, out_valid, multi)
// Parameters:
//   STABLE_CYCLES  consecutive identical samples required before encoding (1..15)
// Build options:
//   ROUND_ROBIN_EN  when defined, the low line is chosen round-robin starting
//                   at a pointer that advances past each accepted index; when
//                   undefined, the lowest index wins and there is no pointer.
module encoder4to2_sampled #(
  parameter int STABLE_CYCLES = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  encoder4to2_sampled_if.slave        bus
);

  localparam logic [3:0] STABLE_L = 4'(STABLE_CYCLES);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETTLE   = 2'd1,
    HOLD     = 2'd2,
    WAIT_REL = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] samp_q, samp_d;
  logic       a_q, a_d;
  logic       b_q, b_d;
  logic       multi_q, multi_d;
  logic       valid_q, valid_d;
  logic       active;
  logic [3:0] low_lines;
  logic [1:0] sel_idx;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    popcount4 = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

`ifdef ROUND_ROBIN_EN
  logic [1:0] ptr_q, ptr_d;

  // Search upward from the pointer, wrapping 3 -> 0 through 2-bit arithmetic.
  function automatic logic [1:0] pick_rr(input logic [3:0] low, input logic [1:0] p);
    logic       found;
    logic [1:0] idx;
    pick_rr = p;
    found   = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = p + 2'(k);
      if (!found && low[idx]) begin
        pick_rr = idx;
        found   = 1'b1;
      end
    end
  endfunction

  assign sel_idx = pick_rr(low_lines, ptr_q);
`else
  function automatic logic [1:0] pick_fixed(input logic [3:0] low);
    if (low[0])      pick_fixed = 2'd0;
    else if (low[1]) pick_fixed = 2'd1;
    else if (low[2]) pick_fixed = 2'd2;
    else             pick_fixed = 2'd3;
  endfunction

  assign sel_idx = pick_fixed(low_lines);
`endif

  assign active    = !bus.en && (bus.y_n != 4'b1111);
  // The captured pattern equals y_n on the issuing edge, so encode from it.
  assign low_lines = ~samp_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    samp_d  = samp_q;
    a_d     = a_q;
    b_d     = b_q;
    multi_d = multi_q;
    valid_d = valid_q;
`ifdef ROUND_ROBIN_EN
    ptr_d   = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        samp_d = bus.y_n;
        if (active) begin
          state_d = SETTLE;
          cnt_d   = 4'd1;
        end
      end
      SETTLE: begin
        samp_d = bus.y_n;
        if (!active) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (bus.y_n != samp_q) begin
          cnt_d = 4'd1;
        end else if (cnt_q < STABLE_L) begin
          cnt_d = cnt_q + 4'd1;
        end else begin
          // Counter holds at STABLE_L here; it never wraps.
          a_d     = sel_idx[1];
          b_d     = sel_idx[0];
          multi_d = (popcount4(low_lines) >= 3'd2);
          valid_d = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        // Inputs other than out_ready are ignored until the code is taken.
        if (bus.out_ready) begin
          valid_d = 1'b0;
          state_d = WAIT_REL;
`ifdef ROUND_ROBIN_EN
          ptr_d   = {a_q, b_q} + 2'd1;
`endif
        end
      end
      WAIT_REL: begin
        if ((bus.y_n == 4'b1111) || bus.en) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      samp_q  <= 4'b1111;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      multi_q <= 1'b0;
      valid_q <= 1'b0;
`ifdef ROUND_ROBIN_EN
      ptr_q   <= 2'd0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      samp_q  <= samp_d;
      a_q     <= a_d;
      b_q     <= b_d;
      multi_q <= multi_d;
      valid_q <= valid_d;
`ifdef ROUND_ROBIN_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  assign bus.a         = a_q;
  assign bus.b         = b_q;
  assign bus.multi     = multi_q;
  assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_encoder4to2_sampled.sv
// Purpose: directed bench for encoder4to2_sampled (STABLE_CYCLES=2). Expected
//          codes {a,b,multi} are queued by the stimulus process; a monitor
//          pops and compares on every handshake. Respects ROUND_ROBIN_EN.
module tb_encoder4to2_sampled;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  int   n_hs;
  logic [2:0] exp_q[$];

  encoder4to2_sampled_if bus_if();

  encoder4to2_sampled #(.STABLE_CYCLES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_hs(input int target);
    for (int i = 0; i < 30 && n_hs < target; i++) @(posedge clk);
    #1;
    check("handshake_seen", 32'(n_hs >= target), 32'd1);
  endtask

  // Monitor: a handshake happens on the next rising edge.
  always @(negedge clk) begin
    logic [2:0] got;
    logic [2:0] exp;
    if (!rst && bus_if.out_valid && bus_if.out_ready) begin
      got = {bus_if.a, bus_if.b, bus_if.multi};
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_code actual=%b required=none", got);
      end else begin
        exp = exp_q.pop_front();
        check("code_abm", 32'(got), 32'(exp));
      end
      n_hs++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ok;
    int   hs0;
    n_cmp = 0; n_err = 0; n_hs = 0;
    rst = 1'b1;
    bus_if.en = 1'b1;
    bus_if.y_n = 4'b1111;
    bus_if.out_ready = 1'b0;
    step(3);
    check("reset_outs", 32'({bus_if.a, bus_if.b, bus_if.out_valid, bus_if.multi}), 32'd0);
    rst = 1'b0;
    step(2);

    // Test 2: single line 1, held 10 cycles, then accepted once.
    bus_if.en = 1'b0;
    bus_if.y_n = 4'b1101;
    step(2);
    check("t2_not_yet", 32'(bus_if.out_valid), 32'd0);
    step(1);
    check("t2_valid", 32'(bus_if.out_valid), 32'd1);
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (!bus_if.out_valid) ok = 1'b0;
    end
    check("t2_held10", 32'(ok), 32'd1);
    exp_q.push_back({2'b01, 1'b0});
    hs0 = n_hs;
    bus_if.out_ready = 1'b1;
    wait_hs(hs0 + 1);
    check("t2_valid_drop", 32'(bus_if.out_valid), 32'd0);
    ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(1);
      if (bus_if.out_valid) ok = 1'b0;
    end
    check("t2_no_reissue", 32'(ok), 32'd1);
    bus_if.y_n = 4'b1111;
    step(2);
    bus_if.out_ready = 1'b0;

    // Test 3: one-cycle glitch rejected.
    bus_if.y_n = 4'b1011;
    step(1);
    bus_if.y_n = 4'b1111;
    ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(1);
      if (bus_if.out_valid) ok = 1'b0;
    end
    check("t3_glitch", 32'(ok), 32'd1);

    // Test 1: async reset while holding a code.
    bus_if.y_n = 4'b0111;
    step(3);
    check("t1_hold_code", 32'({bus_if.a, bus_if.b, bus_if.out_valid}), 32'b111);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("t1_async_rst", 32'({bus_if.a, bus_if.b, bus_if.out_valid, bus_if.multi}), 32'd0);
    bus_if.y_n = 4'b1111;
    step(1);
    rst = 1'b0;
    step(1);

    // Test 4: two low lines, issued twice across a release.
    exp_q.push_back({2'b00, 1'b1});
`ifdef ROUND_ROBIN_EN
    exp_q.push_back({2'b11, 1'b1});
`else
    exp_q.push_back({2'b00, 1'b1});
`endif
    bus_if.out_ready = 1'b1;
    bus_if.y_n = 4'b0110;
    hs0 = n_hs;
    wait_hs(hs0 + 1);
    bus_if.y_n = 4'b1111;
    step(2);
    bus_if.y_n = 4'b0110;
    wait_hs(hs0 + 2);
    bus_if.y_n = 4'b1111;
    bus_if.out_ready = 1'b0;
    step(2);

    // Test 5: disabled encoder ignores lines; enable rising in HOLD keeps the code.
    bus_if.en = 1'b1;
    bus_if.y_n = 4'b0000;
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (bus_if.out_valid) ok = 1'b0;
    end
    check("t5_disabled", 32'(ok), 32'd1);
    bus_if.en = 1'b0;
    step(2);
    check("t5_not_yet", 32'(bus_if.out_valid), 32'd0);
    step(1);
    check("t5_valid", 32'(bus_if.out_valid), 32'd1);
    bus_if.en = 1'b1;
    step(3);
    check("t5_held_en1", 32'(bus_if.out_valid), 32'd1);
    exp_q.push_back({2'b00, 1'b1});
    hs0 = n_hs;
    bus_if.out_ready = 1'b1;
    wait_hs(hs0 + 1);
    bus_if.out_ready = 1'b0;
    bus_if.y_n = 4'b1111;
    step(2);

    // Test 6: pattern change at cnt=1 restarts the filter.
    bus_if.en = 1'b0;
    bus_if.y_n = 4'b1110;
    step(1);
    bus_if.y_n = 4'b0111;
    step(1);
    check("t6_restart0", 32'(bus_if.out_valid), 32'd0);
    step(1);
    check("t6_restart1", 32'(bus_if.out_valid), 32'd0);
    step(1);
    check("t6_valid", 32'(bus_if.out_valid), 32'd1);
    exp_q.push_back({2'b11, 1'b0});
    hs0 = n_hs;
    bus_if.out_ready = 1'b1;
    wait_hs(hs0 + 1);
    bus_if.out_ready = 1'b0;
    bus_if.y_n = 4'b1111;
    step(2);

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
